// File: rtl/escalonador_semaforo.sv
`default_nettype none
// ============================================================================
//  Module   : escalonador_semaforo
//  Purpose  : Round-robin scheduler for a two-way intersection with a
//             pedestrian crossing. Grants the crossing to car direction A,
//             car direction B or pedestrians. Every change of owner passes
//             through yellow and all-red clearance. A flashing-yellow
//             override (pisca) pre-empts everything.
//
//  Ports    : clk          in   system clock, rising edge
//             rst          in   asynchronous reset, active-low
//             pisca        in   level, forces flashing yellow
//             req_a        in   level, car detector direction A
//             req_b        in   level, car detector direction B
//             botao_ped    in   pedestrian button (any pulse length)
//             estado       out  [2:0] current state code
//             luz_a        out  [2:0] {vermelho, amarelo, verde} direction A
//             luz_b        out  [2:0] {vermelho, amarelo, verde} direction B
//             luz_ped      out  [1:0] {vermelho, verde} pedestrians
//             concedido    out  [1:0] owner 0=A 1=B 2=pedestrian 3=none
//             ped_pendente out  latched pedestrian request
//             tempo_restante out [CW-1:0] cycles left in the current dwell
//                          (only with CONTADOR_REGRESSIVO_EN defined)
//
//  Options  : `define CONTADOR_REGRESSIVO_EN to add the countdown output.
//
//  Revision : 1.0 - initial release
// ============================================================================
module escalonador_semaforo #(
  parameter int unsigned T_VERDE_MIN  = 6,   // minimum car-green dwell
  parameter int unsigned T_VERDE_MAX  = 12,  // max car-green while others wait
  parameter int unsigned T_AMARELO    = 2,   // car-yellow dwell
  parameter int unsigned T_TODOS_VERM = 1,   // all-red clearance dwell
  parameter int unsigned T_PED        = 4,   // pedestrian-green dwell
  parameter int unsigned T_PISCA      = 5,   // pedestrian-flash dwell
  parameter int unsigned CW           = 5    // dwell counter width
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pisca,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          botao_ped,
  output logic [2:0]    estado,
  output logic [2:0]    luz_a,
  output logic [2:0]    luz_b,
  output logic [1:0]    luz_ped,
  output logic [1:0]    concedido,
  output logic          ped_pendente
`ifdef CONTADOR_REGRESSIVO_EN
  ,
  output logic [CW-1:0] tempo_restante
`endif
);

  // --------------------------------------------------------------------------
  // State encoding (codes are visible on the estado port)
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_VERDE      = 3'b000,
    S_AMARELO    = 3'b100,
    S_TODOS_VERM = 3'b001,
    S_PED_VERDE  = 3'b101,
    S_PED_PISCA  = 3'b110,
    S_PISCA      = 3'b010
  } estado_t;

  // Requester identifiers, also the concedido encoding
  localparam logic [1:0] C_A    = 2'd0;
  localparam logic [1:0] C_B    = 2'd1;
  localparam logic [1:0] C_PED  = 2'd2;
  localparam logic [1:0] C_NONE = 2'd3;

  // Lamp patterns
  localparam logic [2:0] L_VERM  = 3'b100;
  localparam logic [2:0] L_AMAR  = 3'b010;
  localparam logic [2:0] L_VERDE = 3'b001;
  localparam logic [1:0] P_VERM  = 2'b10;
  localparam logic [1:0] P_VERDE = 2'b01;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  estado_t       estado_q,  estado_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [1:0]    ptr_q,     ptr_d;      // first candidate of the next arbitration
  logic          owner_q,   owner_d;    // car owner in VERDE/AMARELO: 0=A 1=B
  logic          ped_q,     ped_d;
  logic [2:0]    luz_a_q,   luz_a_d;
  logic [2:0]    luz_b_q,   luz_b_d;
  logic [1:0]    luz_ped_q, luz_ped_d;
  logic [1:0]    conc_q,    conc_d;
`ifdef CONTADOR_REGRESSIVO_EN
  logic [CW-1:0] tempo_q,   tempo_d;
`endif

  // --------------------------------------------------------------------------
  // Round-robin arbitration
  // --------------------------------------------------------------------------
  // Position 'k' steps after 'base' in the cyclic order A -> B -> pedestrian.
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    while (s >= 3) s = s - 3;
    return 2'(s);
  endfunction

  logic [3:0] cand;
  logic [1:0] win;

  assign cand = {1'b0, ped_q, req_b, req_a};

  // Scan from the farthest position back to the pointer so that the closest
  // active candidate is the last one written and therefore wins. With no
  // active candidate A wins by default.
  always_comb begin
    win = C_A;
    for (int k = 2; k >= 0; k--) begin
      if (cand[rr_idx(ptr_q, k)]) begin
        win = rr_idx(ptr_q, k);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic own_req;
  logic other_pend;

  assign own_req    = owner_q ? req_b : req_a;
  assign other_pend = (owner_q ? req_a : req_b) | ped_q;

  always_comb begin
    estado_d = estado_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;

    if (pisca) begin
      estado_d = S_PISCA;
    end else begin
      case (estado_q)
        S_VERDE: begin
          if ((cnt_q >= CW'(T_VERDE_MIN - 1)) && other_pend &&
              (!own_req || (cnt_q >= CW'(T_VERDE_MAX - 1)))) begin
            estado_d = S_AMARELO;
          end
        end
        S_AMARELO: begin
          if (cnt_q >= CW'(T_AMARELO - 1)) estado_d = S_TODOS_VERM;
        end
        S_TODOS_VERM: begin
          if (cnt_q >= CW'(T_TODOS_VERM - 1)) begin
            ptr_d = rr_idx(win, 1);
            if (win == C_PED) begin
              estado_d = S_PED_VERDE;
            end else begin
              estado_d = S_VERDE;
              owner_d  = win[0];
            end
          end
        end
        S_PED_VERDE: begin
          if (cnt_q >= CW'(T_PED - 1)) estado_d = S_PED_PISCA;
        end
        S_PED_PISCA: begin
          if (cnt_q >= CW'(T_PISCA - 1)) estado_d = S_TODOS_VERM;
        end
        S_PISCA: begin
          // Leaving the override restarts the rotation at A.
          estado_d = S_TODOS_VERM;
          ptr_d    = C_A;
        end
        default: begin
          estado_d = S_TODOS_VERM;
        end
      endcase
    end
  end

  // Dwell counter: clears on each state entry. In VERDE it stops at
  // T_VERDE_MAX-1 so a late-arriving competitor still ends an overlong green
  // immediately; elsewhere it simply saturates at all-ones.
  always_comb begin
    if (estado_d != estado_q) begin
      cnt_d = '0;
    end else if (estado_q == S_VERDE) begin
      cnt_d = (cnt_q < CW'(T_VERDE_MAX - 1)) ? cnt_q + CW'(1) : cnt_q;
    end else begin
      cnt_d = (cnt_q != '1) ? cnt_q + CW'(1) : cnt_q;
    end
  end

  // Pedestrian latch: cleared when the walk phase or the override is entered;
  // the button is ignored while already walking or flashing.
  always_comb begin
    if ((estado_d == S_PED_VERDE) || (estado_d == S_PISCA)) begin
      ped_d = 1'b0;
    end else if ((estado_q != S_PED_VERDE) && (estado_q != S_PISCA) && botao_ped) begin
      ped_d = 1'b1;
    end else begin
      ped_d = ped_q;
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs, decoded from the state being entered
  // --------------------------------------------------------------------------
  logic blink;

  always_comb begin
    luz_a_d   = L_VERM;
    luz_b_d   = L_VERM;
    luz_ped_d = P_VERM;
    conc_d    = C_NONE;
    blink     = 1'b1;

    case (estado_d)
      S_VERDE: begin
        conc_d = {1'b0, owner_d};
        if (owner_d) luz_b_d = L_VERDE;
        else         luz_a_d = L_VERDE;
      end
      S_AMARELO: begin
        conc_d = {1'b0, owner_d};
        if (owner_d) luz_b_d = L_AMAR;
        else         luz_a_d = L_AMAR;
      end
      S_PED_VERDE: begin
        conc_d    = C_PED;
        luz_ped_d = P_VERDE;
      end
      S_PED_PISCA: begin
        // Red lamp starts lit on entry, then inverts every cycle.
        conc_d    = C_PED;
        blink     = (estado_q == S_PED_PISCA) ? ~luz_ped_q[1] : 1'b1;
        luz_ped_d = {blink, 1'b0};
      end
      S_PISCA: begin
        // Both yellows start lit on entry, then invert every cycle.
        blink     = (estado_q == S_PISCA) ? ~luz_a_q[1] : 1'b1;
        luz_a_d   = {1'b0, blink, 1'b0};
        luz_b_d   = {1'b0, blink, 1'b0};
        luz_ped_d = 2'b00;
      end
      default: begin
        // TODOS_VERM: everything red, nobody owns the crossing
      end
    endcase
  end

`ifdef CONTADOR_REGRESSIVO_EN
  // Remaining cycles of the dwell being entered; VERDE counts against the
  // maximum green, PISCA has no dwell and reads 0.
  int unsigned dwell;

  always_comb begin
    case (estado_d)
      S_VERDE:      dwell = T_VERDE_MAX;
      S_AMARELO:    dwell = T_AMARELO;
      S_TODOS_VERM: dwell = T_TODOS_VERM;
      S_PED_VERDE:  dwell = T_PED;
      S_PED_PISCA:  dwell = T_PISCA;
      default:      dwell = 0;
    endcase
    if (dwell <= (32'(cnt_d) + 32'd1)) tempo_d = '0;
    else                              tempo_d = CW'(dwell - 32'(cnt_d) - 32'd1);
  end
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q  <= S_TODOS_VERM;
      cnt_q     <= '0;
      ptr_q     <= C_A;
      owner_q   <= 1'b0;
      ped_q     <= 1'b0;
      luz_a_q   <= L_VERM;
      luz_b_q   <= L_VERM;
      luz_ped_q <= P_VERM;
      conc_q    <= C_NONE;
`ifdef CONTADOR_REGRESSIVO_EN
      tempo_q   <= '0;
`endif
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      ped_q     <= ped_d;
      luz_a_q   <= luz_a_d;
      luz_b_q   <= luz_b_d;
      luz_ped_q <= luz_ped_d;
      conc_q    <= conc_d;
`ifdef CONTADOR_REGRESSIVO_EN
      tempo_q   <= tempo_d;
`endif
    end
  end

  assign estado       = estado_q;
  assign luz_a        = luz_a_q;
  assign luz_b        = luz_b_q;
  assign luz_ped      = luz_ped_q;
  assign concedido    = conc_q;
  assign ped_pendente = ped_q;
`ifdef CONTADOR_REGRESSIVO_EN
  assign tempo_restante = tempo_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_escalonador_semaforo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_escalonador_semaforo
//  Purpose  : Self-checking bench for escalonador_semaforo. Directed scenarios
//             plus randomized traffic compared against a phase/elapsed-time
//             reference model of the intersection rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_escalonador_semaforo;

  localparam int T_VERDE_MIN  = 6;
  localparam int T_VERDE_MAX  = 12;
  localparam int T_AMARELO    = 2;
  localparam int T_TODOS_VERM = 1;
  localparam int T_PED        = 4;
  localparam int T_PISCA      = 5;
  localparam int CW           = 5;

  // {estado, luz_a, luz_b, luz_ped, concedido, ped_pendente}
  localparam logic [13:0] RST_VEC = {3'b001, 3'b100, 3'b100, 2'b10, 2'b11, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pisca = 1'b0, req_a = 1'b0, req_b = 1'b0, botao_ped = 1'b0;
  logic [2:0] estado, luz_a, luz_b;
  logic [1:0] luz_ped, concedido;
  logic       ped_pendente;
`ifdef CONTADOR_REGRESSIVO_EN
  logic [CW-1:0] tempo_restante;
`endif
  logic [13:0] dut_vec;

  int errors = 0;
  int checks = 0;

  escalonador_semaforo #(
    .T_VERDE_MIN(T_VERDE_MIN), .T_VERDE_MAX(T_VERDE_MAX), .T_AMARELO(T_AMARELO),
    .T_TODOS_VERM(T_TODOS_VERM), .T_PED(T_PED), .T_PISCA(T_PISCA), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .pisca(pisca), .req_a(req_a), .req_b(req_b),
    .botao_ped(botao_ped), .estado(estado), .luz_a(luz_a), .luz_b(luz_b),
    .luz_ped(luz_ped), .concedido(concedido), .ped_pendente(ped_pendente)
`ifdef CONTADOR_REGRESSIVO_EN
    , .tempo_restante(tempo_restante)
`endif
  );

  always #5 clk = ~clk;

  assign dut_vec = {estado, luz_a, luz_b, luz_ped, concedido, ped_pendente};

  // --------------------------------------------------------------------------
  // Reference model: a phase plus the number of whole cycles spent in it.
  // --------------------------------------------------------------------------
  localparam int P_GREEN = 0, P_YEL = 1, P_CLEAR = 2, P_WALK = 3, P_WALKFL = 4, P_FLASH = 5;
  int m_phase, m_t, m_owner, m_start;
  bit m_ped;

  task automatic model_reset();
    m_phase = P_CLEAR; m_t = 0; m_owner = 0; m_start = 0; m_ped = 0;
  endtask

  // Advance one clock using the inputs currently applied.
  task automatic model_step();
    int  np, w;
    bit  own, other;
    bit  act [3];
    np = m_phase;
    if (pisca) np = P_FLASH;
    else case (m_phase)
      P_GREEN: begin
        own   = (m_owner == 0) ? req_a : req_b;
        other = ((m_owner == 0) ? req_b : req_a) | m_ped;
        if (m_t >= T_VERDE_MIN - 1 && other && (!own || m_t >= T_VERDE_MAX - 1)) np = P_YEL;
      end
      P_YEL:    if (m_t >= T_AMARELO - 1) np = P_CLEAR;
      P_CLEAR: if (m_t >= T_TODOS_VERM - 1) begin
        act[0] = req_a; act[1] = req_b; act[2] = m_ped;
        w = -1;
        for (int k = 0; k < 3 && w < 0; k++) if (act[(m_start + k) % 3]) w = (m_start + k) % 3;
        if (w < 0) w = 0;
        m_start = (w + 1) % 3;
        if (w == 2) np = P_WALK;
        else begin np = P_GREEN; m_owner = w; end
      end
      P_WALK:   if (m_t >= T_PED - 1) np = P_WALKFL;
      P_WALKFL: if (m_t >= T_PISCA - 1) np = P_CLEAR;
      default:  begin np = P_CLEAR; m_start = 0; end
    endcase
    if (np == P_WALK || np == P_FLASH) m_ped = 0;
    else if (m_phase != P_WALK && m_phase != P_FLASH && botao_ped) m_ped = 1;
    m_t = (np == m_phase) ? m_t + 1 : 0;
    m_phase = np;
  endtask

  function automatic logic [13:0] mvec();
    logic [2:0] e, la, lb;
    logic [1:0] lp, c;
    la = 3'b100; lb = 3'b100; lp = 2'b10; c = 2'd3;
    case (m_phase)
      P_GREEN:  begin e = 3'b000; c = 2'(m_owner); if (m_owner == 0) la = 3'b001; else lb = 3'b001; end
      P_YEL:    begin e = 3'b100; c = 2'(m_owner); if (m_owner == 0) la = 3'b010; else lb = 3'b010; end
      P_CLEAR:  e = 3'b001;
      P_WALK:   begin e = 3'b101; lp = 2'b01; c = 2'd2; end
      P_WALKFL: begin e = 3'b110; lp = (m_t % 2 == 0) ? 2'b10 : 2'b00; c = 2'd2; end
      default:  begin e = 3'b010; la = (m_t % 2 == 0) ? 3'b010 : 3'b000; lb = la; lp = 2'b00; end
    endcase
    return {e, la, lb, lp, c, m_ped};
  endfunction

`ifdef CONTADOR_REGRESSIVO_EN
  function automatic int m_tempo();
    int d;
    case (m_phase)
      P_GREEN:  d = T_VERDE_MAX;
      P_YEL:    d = T_AMARELO;
      P_CLEAR:  d = T_TODOS_VERM;
      P_WALK:   d = T_PED;
      P_WALKFL: d = T_PISCA;
      default:  d = 0;
    endcase
    return (d - 1 - m_t > 0) ? d - 1 - m_t : 0;
  endfunction
`endif

  // One clock: model follows the inputs (or stays reset), ends at negedge.
  task automatic tick();
    if (rst) model_step(); else model_reset();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    pisca = 0; req_a = 0; req_b = 0; botao_ped = 0;
    rst = 0; model_reset();
    tick();
    rst = 1;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    #1 rst = 0; model_reset();
    @(negedge clk);
    checks++;
    if (dut_vec !== RST_VEC) begin errors++; $display("FAIL reset_values: got %b want %b", dut_vec, RST_VEC); end
`ifdef CONTADOR_REGRESSIVO_EN
    checks++;
    if (tempo_restante !== '0) begin errors++; $display("FAIL reset_tempo: got %0d want 0", tempo_restante); end
`endif
    req_a = 1; botao_ped = 1;
    tick();
    checks++;
    if (dut_vec !== RST_VEC) begin errors++; $display("FAIL reset_held: got %b want %b", dut_vec, RST_VEC); end
    req_a = 0; botao_ped = 0;
  endtask

  task automatic test_idle_green();
    do_reset();
    checks++;
    if (estado !== 3'b001) begin errors++; $display("FAIL idle_clear: got %b want 001", estado); end
    tick();
    checks++;
    if ({estado, concedido, luz_a} !== {3'b000, 2'd0, 3'b001}) begin
      errors++; $display("FAIL idle_a_green: got %b want 00000001", {estado, concedido, luz_a});
    end
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (dut_vec !== mvec()) begin errors++; $display("FAIL idle_model c%0d: got %b want %b", i, dut_vec, mvec()); end
    end
    checks++;
    if (estado !== 3'b000) begin errors++; $display("FAIL idle_hold: got %b want 000", estado); end
  endtask

  task automatic test_green_max();
    logic [10:0] exp;
    do_reset();
    req_a = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 3) req_b = 1;
      if (i < 12)       exp = {3'b000, 3'b001, 3'b100, 2'd0};
      else if (i < 14)  exp = {3'b100, 3'b010, 3'b100, 2'd0};
      else if (i == 14) exp = {3'b001, 3'b100, 3'b100, 2'd3};
      else              exp = {3'b000, 3'b100, 3'b001, 2'd1};
      checks++;
      if ({estado, luz_a, luz_b, concedido} !== exp) begin
        errors++; $display("FAIL green_max c%0d: got %b want %b", i, {estado, luz_a, luz_b, concedido}, exp);
      end
      checks++;
      if (dut_vec !== mvec()) begin errors++; $display("FAIL green_max_model c%0d: got %b want %b", i, dut_vec, mvec()); end
    end
  endtask

  task automatic test_ped();
    logic [4:0] exp [13];
    exp = '{5'b100_10, 5'b100_10, 5'b001_10, 5'b101_01, 5'b101_01, 5'b101_01, 5'b101_01,
            5'b110_10, 5'b110_00, 5'b110_10, 5'b110_00, 5'b110_10, 5'b001_10};
    do_reset();
    for (int i = 0; i < 8; i++) tick();   // A green, sampled at cnt=7
    botao_ped = 1;
    tick();
    botao_ped = 0;
    checks++;
    if ({estado, ped_pendente} !== 4'b000_1) begin
      errors++; $display("FAIL ped_latch: got %b want 0001", {estado, ped_pendente});
    end
    for (int i = 0; i < 13; i++) begin
      tick();
      checks++;
      if ({estado, luz_ped} !== exp[i]) begin
        errors++; $display("FAIL ped_seq c%0d: got %b want %b", i, {estado, luz_ped}, exp[i]);
      end
      checks++;
      if (dut_vec !== mvec()) begin errors++; $display("FAIL ped_model c%0d: got %b want %b", i, dut_vec, mvec()); end
    end
  endtask

  task automatic test_back_to_back();
    int exp_own [5];
    logic [2:0] prev;
    int g, run, own;
    exp_own = '{0, 1, 2, 0, 1};
    do_reset();
    req_a = 1; req_b = 1; botao_ped = 1;
    g = 0; run = 0; prev = estado;
    for (int i = 0; i < 120; i++) begin
      tick();
      checks++;
      if (dut_vec !== mvec()) begin errors++; $display("FAIL b2b_model c%0d: got %b want %b", i, dut_vec, mvec()); end
      if (estado != prev && (estado == 3'b000 || estado == 3'b101)) begin
        own = (estado == 3'b101) ? 2 : int'(concedido);
        if (g < 5) begin
          checks++;
          if (own != exp_own[g]) begin errors++; $display("FAIL b2b_owner g%0d: got %0d want %0d", g, own, exp_own[g]); end
        end
        g++;
      end
      if (estado == 3'b000) run++;
      if (prev == 3'b000 && estado != 3'b000) begin
        checks++;
        if (run != T_VERDE_MAX) begin errors++; $display("FAIL b2b_green_len: got %0d want %0d", run, T_VERDE_MAX); end
        run = 0;
      end
      prev = estado;
    end
    checks++;
    if (g < 5) begin errors++; $display("FAIL b2b_grants: got %0d want >=5", g); end
    req_a = 0; req_b = 0; botao_ped = 0;
  endtask

  task automatic test_pisca();
    bit found;
    logic [1:0] ylw;
    do_reset();
    botao_ped = 1;
    tick();
    botao_ped = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (estado == 3'b101) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL pisca_reach_ped: got %b want 101", estado); end
    tick();                                 // PED_VERDE cnt=1
    pisca = 1; botao_ped = 1;
    tick();
    checks++;
    if (dut_vec !== {3'b010, 3'b010, 3'b010, 2'b00, 2'd3, 1'b0}) begin
      errors++; $display("FAIL pisca_entry: got %b want 01001001000110", dut_vec);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      ylw = (i % 2 == 0) ? 2'b00 : 2'b11;
      checks++;
      if ({luz_a[1], luz_b[1]} !== ylw || ped_pendente !== 1'b0) begin
        errors++; $display("FAIL pisca_blink c%0d: got %b%b p%b want %b p0", i, luz_a[1], luz_b[1], ped_pendente, ylw);
      end
    end
    botao_ped = 0; pisca = 0;
    tick();
    checks++;
    if (estado !== 3'b001) begin errors++; $display("FAIL pisca_exit: got %b want 001", estado); end
    tick();
    checks++;
    if ({estado, concedido, luz_a} !== {3'b000, 2'd0, 3'b001}) begin
      errors++; $display("FAIL pisca_a_green: got %b want 00000001", {estado, concedido, luz_a});
    end
  endtask

  task automatic test_async_reset();
    bit found;
    do_reset();
    tick();                                 // A green by default
    req_b = 1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (estado == 3'b100) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL areset_reach_yel: got %b want 100", estado); end
    #2 rst = 0; model_reset();
    #1;
    checks++;
    if (dut_vec !== RST_VEC) begin errors++; $display("FAIL areset_values: got %b want %b", dut_vec, RST_VEC); end
`ifdef CONTADOR_REGRESSIVO_EN
    checks++;
    if (tempo_restante !== '0) begin errors++; $display("FAIL areset_tempo: got %0d want 0", tempo_restante); end
`endif
    @(negedge clk);
    rst = 1;
    tick();                                 // only B requests: B wins
    checks++;
    if (dut_vec !== mvec() || concedido !== 2'd1) begin
      errors++; $display("FAIL areset_after: got %b want %b", dut_vec, mvec());
    end
    req_b = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (pisca) begin if ($urandom_range(0, 7) == 0) pisca = 0; end
      else if ($urandom_range(0, 149) == 0) pisca = 1;
      if ($urandom_range(0, 9) == 0) req_a = ~req_a;
      if ($urandom_range(0, 9) == 0) req_b = ~req_b;
      botao_ped = ($urandom_range(0, 19) == 0);
      tick();
      checks++;
      if (dut_vec !== mvec()) begin errors++; $display("FAIL random_model c%0d: got %b want %b", i, dut_vec, mvec()); end
`ifdef CONTADOR_REGRESSIVO_EN
      checks++;
      if (tempo_restante !== CW'(m_tempo())) begin
        errors++; $display("FAIL random_tempo c%0d: got %0d want %0d", i, tempo_restante, m_tempo());
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_idle_green();
    test_green_max();
    test_ped();
    test_back_to_back();
    test_pisca();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
